// File: rtl/bus_arbiter_split_rr.sv
// Round-robin bus arbiter with one outstanding split transaction.
// A master whose transfer is split is parked (msplit) and masked from normal
// arbitration. When the slave drops s_split, the parked master is re-granted
// with priority, and a one-cycle split_grant pulse is sent to the slave.
module bus_arbiter_split_rr #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned MID_W       = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] breq,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [NUM_MASTERS-1:0] msplit,
  input  logic                   s_split,
  output logic                   split_grant,
  output logic                   bus_busy,
  output logic [MID_W-1:0]       owner
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [MID_W-1:0]       ptr;
  logic [MID_W-1:0]       ptr_nxt;
  logic [MID_W-1:0]       parked;
  logic [MID_W-1:0]       parked_nxt;
  logic [MID_W-1:0]       owner_nxt;
  logic                   pending;
  logic                   pending_nxt;
  logic                   s_split_q;
  logic                   split_rise;
  logic [NUM_MASTERS-1:0] bgrant_nxt;
  logic [NUM_MASTERS-1:0] msplit_nxt;
  logic                   split_grant_nxt;
  logic [NUM_MASTERS-1:0] parked_mask;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   pick_found;
  logic [MID_W-1:0]       pick_idx;
  logic [MID_W-1:0]       cand;

  // s_split rising edge, relative to the previous cycle's sample
  assign split_rise = s_split & ~s_split_q;

  // Requests that may enter normal arbitration; a parked master stays masked
  always_comb begin
    parked_mask = '0;
    if (pending) begin
      parked_mask[parked] = 1'b1;
    end
    eligible = breq & ~parked_mask;
  end

  // Round-robin search: first eligible index after the pointer, with wrap
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = MID_W'((32'(ptr) + i) % NUM_MASTERS);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt       = state;
    bgrant_nxt      = bgrant;
    msplit_nxt      = msplit;
    split_grant_nxt = 1'b0;
    owner_nxt       = owner;
    ptr_nxt         = ptr;
    pending_nxt     = pending;
    parked_nxt      = parked;
    case (state)
      IDLE: begin
        bgrant_nxt = '0;
        if (pending && !s_split && breq[parked]) begin
          // Resume the parked master ahead of everyone else
          bgrant_nxt[parked] = 1'b1;
          msplit_nxt[parked] = 1'b0;
          split_grant_nxt    = 1'b1;
          pending_nxt        = 1'b0;
          owner_nxt          = parked;
          state_nxt          = GRANT;
        end else if (pending && !s_split) begin
          // Parked master gave up its request: abandon the split
          msplit_nxt[parked] = 1'b0;
          pending_nxt        = 1'b0;
        end else if (pick_found) begin
          bgrant_nxt[pick_idx] = 1'b1;
          owner_nxt            = pick_idx;
          ptr_nxt              = pick_idx;
          state_nxt            = GRANT;
        end
      end
      GRANT: begin
        if (split_rise && !pending) begin
          // Split takes precedence over a simultaneous request drop
          bgrant_nxt        = '0;
          msplit_nxt[owner] = 1'b1;
          pending_nxt       = 1'b1;
          parked_nxt        = owner;
          state_nxt         = IDLE;
        end else if (!breq[owner]) begin
          bgrant_nxt = '0;
          state_nxt  = IDLE;
        end
      end
      default: begin
        bgrant_nxt = '0;
        state_nxt  = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bgrant      <= '0;
      msplit      <= '0;
      split_grant <= 1'b0;
      bus_busy    <= 1'b0;
      owner       <= '0;
      ptr         <= MID_W'(NUM_MASTERS - 1);
      pending     <= 1'b0;
      parked      <= '0;
      s_split_q   <= 1'b0;
    end else begin
      bgrant      <= bgrant_nxt;
      msplit      <= msplit_nxt;
      split_grant <= split_grant_nxt;
      bus_busy    <= |bgrant_nxt;
      owner       <= owner_nxt;
      ptr         <= ptr_nxt;
      pending     <= pending_nxt;
      parked      <= parked_nxt;
      s_split_q   <= s_split;
    end
  end

`ifndef SYNTHESIS
  // Structural invariants of the grant outputs
  a_onehot_grant: assert property (@(posedge clk) disable iff (!rstn) $onehot0(bgrant));
  a_split_grant:  assert property (@(posedge clk) disable iff (!rstn) split_grant |-> bgrant[owner]);
  a_busy:         assert property (@(posedge clk) disable iff (!rstn) bus_busy == (|bgrant));
`endif

endmodule

// File: tb/tb_bus_arbiter_split_rr.sv
// Bench for bus_arbiter_split_rr: a 2-master and a 4-master instance driven
// from per-scenario step tables; expectations flow through a scoreboard queue.
module tb_bus_arbiter_split_rr;

  typedef struct packed {
    logic       rst;
    logic [3:0] breq;
    logic       ss;
    logic [3:0] g;
    logic [3:0] ms;
    logic       sg;
    logic [1:0] own;
  } step_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] breq2;
  logic [1:0] bgrant2;
  logic [1:0] msplit2;
  logic       ss2;
  logic       sg2;
  logic       busy2;
  logic [0:0] owner2;
  logic [3:0] breq4;
  logic [3:0] bgrant4;
  logic [3:0] msplit4;
  logic       ss4;
  logic       sg4;
  logic       busy4;
  logic [1:0] owner4;

  int    checks = 0;
  int    errors = 0;
  logic  mon_en = 1'b0;
  step_t sb_q[$];

  always #5 clk = ~clk;

  bus_arbiter_split_rr #(.NUM_MASTERS(2), .MID_W(1)) dut2 (
    .clk(clk), .rstn(rstn), .breq(breq2), .bgrant(bgrant2), .msplit(msplit2),
    .s_split(ss2), .split_grant(sg2), .bus_busy(busy2), .owner(owner2)
  );

  bus_arbiter_split_rr #(.NUM_MASTERS(4), .MID_W(2)) dut4 (
    .clk(clk), .rstn(rstn), .breq(breq4), .bgrant(bgrant4), .msplit(msplit4),
    .s_split(ss4), .split_grant(sg4), .bus_busy(busy4), .owner(owner4)
  );

  function automatic step_t mk(input logic rst, input logic [3:0] breq, input logic ss,
                               input logic [3:0] g, input logic [3:0] ms, input logic sg,
                               input logic [1:0] own);
    step_t s;
    s.rst = rst; s.breq = breq; s.ss = ss; s.g = g; s.ms = ms; s.sg = sg; s.own = own;
    return s;
  endfunction

  // Continuous invariant watch on both instances, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0(bgrant2) || !$onehot0(bgrant4) ||
          (sg2 && !bgrant2[owner2]) || (sg4 && !bgrant4[owner4])) begin
        errors++;
        $display("FAIL invariant t=%0t: got g2=%b sg2=%b g4=%b sg4=%b, required onehot0 grants and split_grant with owner granted",
                 $time, bgrant2, sg2, bgrant4, sg4);
      end
    end
  end

  task automatic test_reset();
    step_t e;
    rstn = 1'b0; breq2 = '0; ss2 = 1'b0; breq4 = '0; ss4 = 1'b0;
    sb_q.push_back(mk(1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0));
    repeat (2) @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if ({bgrant2, msplit2, sg2, busy2, owner2, bgrant4, msplit4, sg4, busy4, owner4} !==
        {e.g[1:0], e.ms[1:0], e.sg, (|e.g), e.own[0], e.g, e.ms, e.sg, (|e.g), e.own}) begin
      errors++;
      $display("FAIL reset: got g2=%b ms2=%b sg2=%b busy2=%b own2=%0d g4=%b ms4=%b sg4=%b busy4=%b own4=%0d, required all zero",
               bgrant2, msplit2, sg2, busy2, owner2, bgrant4, msplit4, sg4, busy4, owner4);
    end
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    step_t t[$];
    step_t e;
    t.push_back(mk(1'b1, 4'b00, 1'b0, 4'b00, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b01, 1'b0, 4'b01, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b00, 1'b0, 4'b00, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b00, 1'b0, 4'b00, 4'b00, 1'b0, 2'd0));
    foreach (t[i]) begin
      rstn = !t[i].rst; breq2 = t[i].breq[1:0]; ss2 = t[i].ss;
      sb_q.push_back(t[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({bgrant2, msplit2, sg2, busy2, owner2} !== {e.g[1:0], e.ms[1:0], e.sg, (|e.g), e.own[0]}) begin
        errors++;
        $display("FAIL basic step %0d: got g=%b ms=%b sg=%b busy=%b own=%0d, required g=%b ms=%b sg=%b busy=%b own=%0d",
                 i, bgrant2, msplit2, sg2, busy2, owner2, e.g[1:0], e.ms[1:0], e.sg, |e.g, e.own[0]);
      end
    end
  endtask

  task automatic test_round_robin();
    step_t t[$];
    step_t e;
    t.push_back(mk(1'b1, 4'b00, 1'b0, 4'b00, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b11, 1'b0, 4'b01, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b11, 1'b0, 4'b01, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b11, 1'b0, 4'b01, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b10, 1'b0, 4'b00, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b11, 1'b0, 4'b10, 4'b00, 1'b0, 2'd1));
    t.push_back(mk(1'b0, 4'b11, 1'b0, 4'b10, 4'b00, 1'b0, 2'd1));
    t.push_back(mk(1'b0, 4'b11, 1'b0, 4'b10, 4'b00, 1'b0, 2'd1));
    t.push_back(mk(1'b0, 4'b01, 1'b0, 4'b00, 4'b00, 1'b0, 2'd1));
    t.push_back(mk(1'b0, 4'b11, 1'b0, 4'b01, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b00, 1'b0, 4'b00, 4'b00, 1'b0, 2'd0));
    foreach (t[i]) begin
      rstn = !t[i].rst; breq2 = t[i].breq[1:0]; ss2 = t[i].ss;
      sb_q.push_back(t[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({bgrant2, msplit2, sg2, busy2, owner2} !== {e.g[1:0], e.ms[1:0], e.sg, (|e.g), e.own[0]}) begin
        errors++;
        $display("FAIL round_robin step %0d: got g=%b ms=%b sg=%b busy=%b own=%0d, required g=%b ms=%b sg=%b busy=%b own=%0d",
                 i, bgrant2, msplit2, sg2, busy2, owner2, e.g[1:0], e.ms[1:0], e.sg, |e.g, e.own[0]);
      end
    end
  endtask

  task automatic test_split();
    step_t t[$];
    step_t e;
    t.push_back(mk(1'b1, 4'b00, 1'b0, 4'b00, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b01, 1'b0, 4'b01, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b01, 1'b1, 4'b00, 4'b01, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b11, 1'b1, 4'b10, 4'b01, 1'b0, 2'd1));
    t.push_back(mk(1'b0, 4'b11, 1'b0, 4'b10, 4'b01, 1'b0, 2'd1));
    t.push_back(mk(1'b0, 4'b11, 1'b1, 4'b10, 4'b01, 1'b0, 2'd1));
    t.push_back(mk(1'b0, 4'b01, 1'b1, 4'b00, 4'b01, 1'b0, 2'd1));
    t.push_back(mk(1'b0, 4'b01, 1'b0, 4'b01, 4'b00, 1'b1, 2'd0));
    t.push_back(mk(1'b0, 4'b01, 1'b0, 4'b01, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b00, 1'b0, 4'b00, 4'b00, 1'b0, 2'd0));
    foreach (t[i]) begin
      rstn = !t[i].rst; breq2 = t[i].breq[1:0]; ss2 = t[i].ss;
      sb_q.push_back(t[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({bgrant2, msplit2, sg2, busy2, owner2} !== {e.g[1:0], e.ms[1:0], e.sg, (|e.g), e.own[0]}) begin
        errors++;
        $display("FAIL split step %0d: got g=%b ms=%b sg=%b busy=%b own=%0d, required g=%b ms=%b sg=%b busy=%b own=%0d",
                 i, bgrant2, msplit2, sg2, busy2, owner2, e.g[1:0], e.ms[1:0], e.sg, |e.g, e.own[0]);
      end
    end
  endtask

  task automatic test_split_resume_priority();
    step_t t[$];
    step_t e;
    t.push_back(mk(1'b1, 4'b00, 1'b0, 4'b00, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b01, 1'b0, 4'b01, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b01, 1'b1, 4'b00, 4'b01, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b00, 1'b1, 4'b00, 4'b01, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b11, 1'b0, 4'b01, 4'b00, 1'b1, 2'd0));
    t.push_back(mk(1'b0, 4'b11, 1'b0, 4'b01, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b10, 1'b0, 4'b00, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b10, 1'b0, 4'b10, 4'b00, 1'b0, 2'd1));
    t.push_back(mk(1'b0, 4'b00, 1'b0, 4'b00, 4'b00, 1'b0, 2'd1));
    foreach (t[i]) begin
      rstn = !t[i].rst; breq2 = t[i].breq[1:0]; ss2 = t[i].ss;
      sb_q.push_back(t[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({bgrant2, msplit2, sg2, busy2, owner2} !== {e.g[1:0], e.ms[1:0], e.sg, (|e.g), e.own[0]}) begin
        errors++;
        $display("FAIL resume step %0d: got g=%b ms=%b sg=%b busy=%b own=%0d, required g=%b ms=%b sg=%b busy=%b own=%0d",
                 i, bgrant2, msplit2, sg2, busy2, owner2, e.g[1:0], e.ms[1:0], e.sg, |e.g, e.own[0]);
      end
    end
  endtask

  task automatic test_split_abandon();
    step_t t[$];
    step_t e;
    t.push_back(mk(1'b1, 4'b00, 1'b0, 4'b00, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b01, 1'b0, 4'b01, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b00, 1'b1, 4'b00, 4'b01, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b01, 1'b1, 4'b00, 4'b01, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b00, 1'b0, 4'b00, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b01, 1'b0, 4'b01, 4'b00, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b00, 1'b0, 4'b00, 4'b00, 1'b0, 2'd0));
    foreach (t[i]) begin
      rstn = !t[i].rst; breq2 = t[i].breq[1:0]; ss2 = t[i].ss;
      sb_q.push_back(t[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({bgrant2, msplit2, sg2, busy2, owner2} !== {e.g[1:0], e.ms[1:0], e.sg, (|e.g), e.own[0]}) begin
        errors++;
        $display("FAIL abandon step %0d: got g=%b ms=%b sg=%b busy=%b own=%0d, required g=%b ms=%b sg=%b busy=%b own=%0d",
                 i, bgrant2, msplit2, sg2, busy2, owner2, e.g[1:0], e.ms[1:0], e.sg, |e.g, e.own[0]);
      end
    end
  endtask

  task automatic test_four_rr();
    step_t t[$];
    step_t e;
    t.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b1110, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b0010, 4'b0000, 1'b0, 2'd1));
    t.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b0010, 4'b0000, 1'b0, 2'd1));
    t.push_back(mk(1'b0, 4'b1101, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1));
    t.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd2));
    t.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd2));
    t.push_back(mk(1'b0, 4'b1011, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2));
    t.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b1000, 4'b0000, 1'b0, 2'd3));
    t.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b1000, 4'b0000, 1'b0, 2'd3));
    t.push_back(mk(1'b0, 4'b0111, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd3));
    t.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0));
    foreach (t[i]) begin
      rstn = !t[i].rst; breq4 = t[i].breq; ss4 = t[i].ss;
      sb_q.push_back(t[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({bgrant4, msplit4, sg4, busy4, owner4} !== {e.g, e.ms, e.sg, (|e.g), e.own}) begin
        errors++;
        $display("FAIL four_rr step %0d: got g=%b ms=%b sg=%b busy=%b own=%0d, required g=%b ms=%b sg=%b busy=%b own=%0d",
                 i, bgrant4, msplit4, sg4, busy4, owner4, e.g, e.ms, e.sg, |e.g, e.own);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t t[$];
    step_t e;
    t.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0001, 1'b0, 2'd1));
    t.push_back(mk(1'b1, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0));
    t.push_back(mk(1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0, 2'd1));
    t.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1));
    foreach (t[i]) begin
      rstn = !t[i].rst; breq4 = t[i].breq; ss4 = t[i].ss;
      sb_q.push_back(t[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({bgrant4, msplit4, sg4, busy4, owner4} !== {e.g, e.ms, e.sg, (|e.g), e.own}) begin
        errors++;
        $display("FAIL reset_mid step %0d: got g=%b ms=%b sg=%b busy=%b own=%0d, required g=%b ms=%b sg=%b busy=%b own=%0d",
                 i, bgrant4, msplit4, sg4, busy4, owner4, e.g, e.ms, e.sg, |e.g, e.own);
      end
    end
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_basic();
    test_round_robin();
    test_split();
    test_split_resume_priority();
    test_split_abandon();
    test_four_rr();
    test_reset_mid();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_split_rr.md
Name: bus_arbiter_split_rr

Overview:
- Parametrised bus arbiter for the serial system bus.
- Supports NUM_MASTERS masters with round-robin fairness and one outstanding split transaction.
- Sits inside the bus interconnect between the master ports (mbreq/mbgrant/msplit) and the split-capable slave (ssplit/split_grant).
- Replaces the fixed two-master priority arbitration and adds master parking across a split plus priority resume.

Parameters:
NUM_MASTERS, 2, number of requesting masters (>=2)
MID_W, 1, width of master index, must equal $clog2(NUM_MASTERS)

Ports:
clk  input  1  system clock
rstn  input  1  synchronous active-low reset, sampled on rising clk
breq  input  NUM_MASTERS  per-master bus request (level)
bgrant  output  NUM_MASTERS  per-master grant, one-hot or zero, registered
msplit  output  NUM_MASTERS  per-master split-parked flag, registered
s_split  input  1  split slave busy; rising while granted = split current transaction
split_grant  output  1  one-cycle pulse to slave when parked master is re-granted
bus_busy  output  1  high whenever any bgrant bit is high
owner  output  MID_W  index of granted or last-granted master

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values: bgrant=0, msplit=0, split_grant=0, bus_busy=0, owner=0.
- Reset: round-robin pointer=NUM_MASTERS-1, so master 0 wins first. No split pending.
- Reset asserted mid-transaction: all state clears on that edge; no split_grant is issued afterwards.
- States:
  - IDLE
  - GRANT
- IDLE, evaluated each cycle, in priority order:
  - (a) Split pending, s_split=0, breq[parked]=1: grant parked master. split_grant=1 for exactly that cycle, coincident with bgrant rising. msplit[parked] clears the same cycle. Pending cleared.
  - (b) Split pending, s_split=0, breq[parked]=0: clear pending and msplit. No grant this cycle.
  - (c) Otherwise: eligible = breq, with the parked master masked while pending. Pick the first eligible index searching from pointer+1 upward with wrap-around. Set bgrant, owner and pointer to it.
  - (d) No eligible request: stay IDLE, outputs 0.
- Grant latency: bgrant rises on the edge after breq is sampled high in IDLE. Minimum 1 cycle from request.
- GRANT:
  - Holds while breq[owner]=1 and no split event.
  - breq[owner]=0: bgrant drops on the next edge, go IDLE.
  - Bus turnaround: at least 1 cycle with bgrant=0 between any two owners.
- Split event = s_split rising (registered edge detect) while in GRANT with no split pending:
  - Next edge: bgrant[owner]=0, msplit[owner]=1, pending=1, parked=owner, go IDLE.
  - msplit stays high until cleared per IDLE (a)/(b).
- Simultaneous split event and breq[owner] drop in the same cycle: the split wins.
- s_split rising while a split is already pending: ignored. Protocol violation; grant unaffected.
- s_split rising in IDLE: edge detector updates, no state change.
- The parked master is never granted via (c) while pending, even if it is the only requester.
- Invariant: bgrant is at most one-hot in every cycle.
- Invariant: split_grant=1 only together with bgrant[parked]=1.

Test Plan:
- NUM_MASTERS=2, breq=01 from idle -> bgrant=01 one cycle later; drop breq -> bgrant=00 next cycle, bus_busy=0.
- breq=11 held, each owner drops and re-raises after 3 granted cycles -> grant sequence 01,00,10,00,01; owner alternates 0,1,0.
- M0 granted, s_split 0->1 -> next cycle bgrant=00, msplit=01. M1 breq -> bgrant=10. M1 releases; s_split=0 -> bgrant=01 with split_grant pulse of one cycle, msplit=00.
- Split pending on M0, s_split falls while M1 and M0 both request in IDLE -> M0 granted first with split_grant, then M1.
- NUM_MASTERS=4, MID_W=2, breq=1111 held, each owner holds 2 cycles -> owners 0,1,2,3,0 in order. Never two grant bits high.
- Reset (rstn=0 one cycle) during split pending with M1 granted -> all outputs 0 next edge. Subsequent s_split fall produces no split_grant. breq=0010 -> bgrant=0010.
